rst_seq: RTL and testbench

Parametrised multi-channel reset sequencer; successor to the single-channel reset synchroniser. Combines an external asynchronous active-low reset request with a software reset pulse, stretches the request to a minimum hold time, then releases CH_NUM per-channel active-high resets one at a time in fixed order, STAGGER cycles apart. Sits at the top of each clock domain and drives reset for the domain's sub-blocks, e.g. PLL-dependent logic first and datapath last.

---
 rtl/rst_seq.sv | 173 +++++++++++++++++
 tb/tb_rst_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: merges an external async request with a software request,
// holds for a minimum time, then releases per-channel resets in ascending order.
module rst_seq #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 16,
   parameter int unsigned STAGGER     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_rstn,
   input  logic              sw_rst,
   output logic [CH_NUM-1:0] rst_out,
   output logic              done
);

   localparam int unsigned CntMax = (STRETCH > STAGGER) ? STRETCH : STAGGER;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned IdxW   = $clog2(CH_NUM + 1);

   localparam logic [CntW-1:0] StretchEnd = CntW'(STRETCH - 1);
   localparam logic [CntW-1:0] StaggerEnd = CntW'(STAGGER - 1);
   localparam logic [IdxW-1:0] LastIdx    = IdxW'(CH_NUM - 1);

   typedef enum logic [1:0] {
      StAssert,
      StHold,
      StRelease,
      StRun
   } state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [CH_NUM-1:0]       rst_out_q, rst_out_d;
   logic                    done_q, done_d;
   logic                    ext_sync;
   logic                    req;

   // Clearing the chain on rst makes the external request look asserted until it resynchronises.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ext_rstn};
   end

   assign ext_sync = sync_q[SYNC_STAGES-1];
   assign req      = ~ext_sync | sw_rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAssert;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (req) begin
         state_d = StAssert;
      end else begin
         unique case (state_q)
            StAssert: begin
               state_d = StHold;
            end
            StHold: begin
               if (cnt_q == StretchEnd) begin
                  state_d = (CH_NUM == 1) ? StRun : StRelease;
               end
            end
            StRelease: begin
               if ((cnt_q == StaggerEnd) && (idx_q == LastIdx)) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               state_d = StRun;
            end
            default: begin
               state_d = StAssert;
            end
         endcase
      end
   end

   // Output and counter next values
   always_comb begin
      rst_out_d = rst_out_q;
      done_d    = done_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      if (req) begin
         rst_out_d = '1;
         done_d    = 1'b0;
         cnt_d     = '0;
         idx_d     = '0;
      end else begin
         unique case (state_q)
            StAssert: begin
               rst_out_d = '1;
               done_d    = 1'b0;
               cnt_d     = '0;
               idx_d     = '0;
            end
            StHold: begin
               if (cnt_q == StretchEnd) begin
                  rst_out_d[0] = 1'b0;
                  cnt_d        = '0;
                  idx_d        = IdxW'(1);
                  if (CH_NUM == 1) begin
                     done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StRelease: begin
               if (cnt_q == StaggerEnd) begin
                  for (int unsigned k = 0; k < CH_NUM; k++) begin
                     if (idx_q == IdxW'(k)) begin
                        rst_out_d[k] = 1'b0;
                     end
                  end
                  idx_d = idx_q + IdxW'(1);
                  cnt_d = '0;
                  if (idx_q == LastIdx) begin
                     done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StRun: begin
               cnt_d = cnt_q;
            end
            default: begin
               rst_out_d = '1;
               done_d    = 1'b0;
               cnt_d     = '0;
               idx_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_out_q <= '1;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign rst_out = rst_out_q;
   assign done    = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: three parameterisations share stimulus; expectations are
// queued with the cycle they apply to and checked by an independent monitor.
module tb_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_rstn;
   logic       sw_rst;
   logic [3:0] rst_out_a;
   logic       done_a;
   logic [0:0] rst_out_b;
   logic       done_b;
   logic [7:0] rst_out_c;
   logic       done_c;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         cyc;
      int         dut;
      logic [7:0] rst;
      logic       done;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rst_seq #(.CH_NUM(4), .SYNC_STAGES(2), .STRETCH(16), .STAGGER(8)) u_a (
      .clk(clk), .rst(rst), .ext_rstn(ext_rstn), .sw_rst(sw_rst),
      .rst_out(rst_out_a), .done(done_a)
   );

   rst_seq #(.CH_NUM(1), .SYNC_STAGES(2), .STRETCH(1), .STAGGER(1)) u_b (
      .clk(clk), .rst(rst), .ext_rstn(ext_rstn), .sw_rst(sw_rst),
      .rst_out(rst_out_b), .done(done_b)
   );

   rst_seq #(.CH_NUM(8), .SYNC_STAGES(2), .STRETCH(4), .STAGGER(3)) u_c (
      .clk(clk), .rst(rst), .ext_rstn(ext_rstn), .sw_rst(sw_rst),
      .rst_out(rst_out_c), .done(done_c)
   );

   task automatic expect_at(input int c, input int d, input logic [7:0] r, input logic dn);
      sb.push_back('{cyc: c, dut: d, rst: r, done: dn});
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: outputs settle after each posedge; compare on the falling edge.
   exp_t       e;
   logic [7:0] act_r;
   logic       act_d;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         case (e.dut)
            0:       begin act_r = {4'b0, rst_out_a}; act_d = done_a; end
            1:       begin act_r = {7'b0, rst_out_b}; act_d = done_b; end
            default: begin act_r = rst_out_c;         act_d = done_c; end
         endcase
         n_cmp++;
         if (e.cyc != cyc || act_r !== e.rst || act_d !== e.done) begin
            n_err++;
            $display("FAIL dut%0d@cyc%0d (seen at %0d): got rst_out=%h done=%b, want rst_out=%h done=%b",
                     e.dut, e.cyc, cyc, act_r, act_d, e.rst, e.done);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int E, F, G, P, Q, R, c;
      logic [7:0] m;
      rst = 1'b1;
      ext_rstn = 1'b0;
      sw_rst = 1'b0;

      // Power-on reset then external release
      repeat (3) @(negedge clk);
      rst = 1'b0;
      expect_at(cyc + 1, 0, 8'h0F, 1'b0);
      expect_at(cyc + 5, 0, 8'h0F, 1'b0);
      wait_cyc(cyc + 5);
      ext_rstn = 1'b1;
      E = cyc + 1;
      expect_at(E + 17, 0, 8'h0F, 1'b0);
      expect_at(E + 18, 0, 8'h0E, 1'b0);
      expect_at(E + 25, 0, 8'h0E, 1'b0);
      expect_at(E + 26, 0, 8'h0C, 1'b0);
      expect_at(E + 33, 0, 8'h0C, 1'b0);
      expect_at(E + 34, 0, 8'h08, 1'b0);
      expect_at(E + 41, 0, 8'h08, 1'b0);
      expect_at(E + 42, 0, 8'h00, 1'b1);
      expect_at(E + 50, 0, 8'h00, 1'b1);
      wait_cyc(E + 50);

      // Software pulse from RUN
      sw_rst = 1'b1;
      E = cyc + 1;
      expect_at(E, 0, 8'h0F, 1'b0);
      expect_at(E + 16, 0, 8'h0F, 1'b0);
      expect_at(E + 17, 0, 8'h0E, 1'b0);
      expect_at(E + 24, 0, 8'h0E, 1'b0);
      expect_at(E + 25, 0, 8'h0C, 1'b0);
      @(negedge clk);
      sw_rst = 1'b0;
      wait_cyc(E + 26);

      // External drop during RELEASE, 5 cycles long
      ext_rstn = 1'b0;
      F = cyc + 1;
      expect_at(F + 1, 0, 8'h0C, 1'b0);
      expect_at(F + 2, 0, 8'h0F, 1'b0);
      wait_cyc(F + 4);
      ext_rstn = 1'b1;
      G = cyc + 1;
      expect_at(G + 1, 0, 8'h0F, 1'b0);
      expect_at(G + 17, 0, 8'h0F, 1'b0);
      expect_at(G + 18, 0, 8'h0E, 1'b0);
      wait_cyc(G + 19);

      // Software request while HOLD has cnt = 10
      sw_rst = 1'b1;
      P = cyc + 1;
      Q = P + 12;
      expect_at(P, 0, 8'h0F, 1'b0);
      expect_at(P + 11, 0, 8'h0F, 1'b0);
      expect_at(Q, 0, 8'h0F, 1'b0);
      expect_at(Q + 16, 0, 8'h0F, 1'b0);
      expect_at(Q + 17, 0, 8'h0E, 1'b0);
      @(negedge clk);
      sw_rst = 1'b0;
      wait_cyc(P + 11);
      sw_rst = 1'b1;
      @(negedge clk);
      sw_rst = 1'b0;
      wait_cyc(Q + 20);

      // Master reset mid-sequence; sync chain must be re-filled
      rst = 1'b1;
      R = cyc + 1;
      expect_at(R, 0, 8'h0F, 1'b0);
      expect_at(R + 2, 0, 8'h0F, 1'b0);
      expect_at(R + 18, 0, 8'h0F, 1'b0);
      expect_at(R + 19, 0, 8'h0E, 1'b0);
      expect_at(R + 42, 0, 8'h08, 1'b0);
      expect_at(R + 43, 0, 8'h00, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(R + 44);

      // Parameter sweep: single minimal channel and eight channels, stagger 3
      rst = 1'b1;
      ext_rstn = 1'b0;
      c = cyc;
      wait_cyc(c + 2);
      rst = 1'b0;
      wait_cyc(c + 5);
      ext_rstn = 1'b1;
      E = cyc + 1;
      expect_at(E + 1, 1, 8'h01, 1'b0);
      expect_at(E + 1, 2, 8'hFF, 1'b0);
      expect_at(E + 2, 1, 8'h01, 1'b0);
      expect_at(E + 3, 1, 8'h00, 1'b1);
      for (int k = 0; k < 8; k++) begin
         m = 8'hFF;
         m = m << k;
         expect_at(E + 5 + 3 * k, 2, m, 1'b0);
         m = m << 1;
         expect_at(E + 6 + 3 * k, 2, m, (k == 7));
      end
      wait_cyc(E + 28);
      @(negedge clk);

      if (sb.size() != 0) begin
         n_err += sb.size();
         $display("FAIL scoreboard: %0d expectations never checked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
